// File: rtl/risc_v_lite_pkg.sv
// Shared definitions for the RISC-V lite instruction-memory loader:
// datapath width, word-to-byte address shift and the loader FSM states.
package risc_v_lite_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  function automatic logic [XLEN-1:0] word_to_byte_addr(input logic [XLEN-1:0] word_idx);
    return word_idx << WORD_SHIFT;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Synchronous registered FIFO buffering incoming instruction words.
// Pointers carry one wrap bit so full and empty are told apart without a counter.
module loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: buffers file words and writes them to IMEM while
// holding the CPU in reset. Optional XOR checksum output: IMEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | first cycle after reset, FIFO flushed
// LOAD  | accepting words until End_file is seen
// DRAIN | writing out words still buffered
// DONE  | image written, CPU released (terminal until Rst)
module imem_loader
  import risc_v_lite_pkg::*;
#(
  parameter int IMEM_AW    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             DataIN_valid,
  input  logic [31:0]      DataIN_to_mem,
  input  logic             End_file,
  output logic             DataIN_ready,
  output logic             WR,
  output logic [31:0]      Address,
  output logic [31:0]      Instr_to_mem,
  output logic             Cpu_Rst,
  output logic             Load_done,
  output logic             Overflow,
  output logic [IMEM_AW:0] Word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      Checksum
`endif
);

  localparam logic [IMEM_AW:0] MAX_WORDS = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] CNT_ONE   = {{IMEM_AW{1'b0}}, 1'b1};

  loader_state_e    state_q, state_d;
  logic [IMEM_AW:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [XLEN-1:0]  fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             writing_phase;
  logic             mem_full;
  logic             wr;

  assign writing_phase = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign mem_full      = (count_q == MAX_WORDS);

  assign DataIN_ready = (state_q == ST_LOAD) && !fifo_full;
  assign fifo_push    = DataIN_valid && DataIN_ready;
  assign fifo_pop     = writing_phase && !fifo_empty;
  assign fifo_flush   = (state_q == ST_IDLE);

  // Words popped once the memory is full are dropped rather than written.
  assign wr = fifo_pop && !mem_full;

  loader_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(XLEN)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .flush_i    (fifo_flush),
    .push_i     (fifo_push),
    .push_data_i(DataIN_to_mem),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (wr) count_d = count_q + CNT_ONE;
    if (fifo_pop && mem_full) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE:  state_d = ST_LOAD;
      ST_LOAD:  if (End_file) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign WR           = wr;
  assign Instr_to_mem = wr ? fifo_head : '0;
  assign Address      = word_to_byte_addr(XLEN'(count_q));
  assign Word_count   = count_q;
  assign Overflow     = ovf_q;
  assign Cpu_Rst      = (state_q != ST_DONE);
  assign Load_done    = (state_q == ST_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (wr) chk_d = chk_q ^ fifo_head;
  end

  always_ff @(posedge Clk) begin
    if (Rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign Checksum = chk_q;
`endif

endmodule
